present_sbox_nibble_sequencer: RTL and testbench
================================================

// Module: present_sbox_nibble_sequencer
// PURPOSE
//  Sequences the 2-share masked PRESENT S-box step gadget (4-bit GHPC S-box, r[63:0]) over a 64-bit state.
//  Nibble-serial operation: one nibble is issued per fresh 64-bit randomness word, and result nibbles are collected back into a 64-bit state.
//  Sits between the round datapath (state/key registers) and the single shared S-box gadget instance.
//  Generates the gadget enable used for clock gating of the gadget registers.
// PARAMETERS
//  SBOX_LAT  1  gadget latency in cycles, issue -> result valid (0..4).
//               0 = combinational gadget; the result is captured in the issue cycle.
//  NIBBLES   16 nibbles per state; fixed at 16 for PRESENT-80.
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   pulse: latch state_in0/1 and begin a 16-nibble pass
//  state_in0  in   64  share 0 of the input state
//  state_in1  in   64  share 1 of the input state
//  busy       out  1   high from the cycle after accepted start until done
//  done       out  1   one-cycle pulse when state_out0/1 are complete
//  state_out0 out  64  share 0 of the S-box layer result (held until next start)
//  state_out1 out  64  share 1 of the S-box layer result (held until next start)
//  rnd_valid  in   1   PRNG word available
//  rnd_ready  out  1   sequencer consumes rnd_in this cycle if rnd_valid
//  rnd_in     in   64  fresh randomness word
//  sbox_en    out  1   issue strobe / gadget clock-gate enable
//  sbox_in0   out  4   gadget input, share 0
//  sbox_in1   out  4   gadget input, share 1
//  sbox_r     out  64  gadget randomness
//  sbox_out0  in   4   gadget output, share 0
//  sbox_out1  in   4   gadget output, share 1
// BEHAVIOUR
//  Reset values: all outputs 0, FSM in IDLE, counters 0, pipeline tokens cleared.
//  sbox_in/sbox_r are forced to 0 when not issuing, so no stale shares are present on idle cycles.
//  FSM states:
//   IDLE:  start=1 -> latch both shares into the input shift registers.
//          Clear issue_cnt and collect_cnt; go to ISSUE. start is ignored in every other state.
//   ISSUE: rnd_ready=1. Each cycle with rnd_valid=1 is an issue:
//          - sbox_en=1
//          - sbox_in0/1 = nibble issue_cnt (nibble 0 = bits[3:0] first)
//          - sbox_r = rnd_in
//          - push a token into a SBOX_LAT-deep valid pipe
//          - shift the input registers right by 4 and increment issue_cnt
//          Cycles with rnd_valid=0 issue nothing and create bubbles.
//          After the 16th issue: rnd_ready=0 and go to DRAIN.
//   DRAIN: wait for outstanding tokens. At collect_cnt=16 -> go to DONE.
//   DONE:  done=1 and busy=0 for one cycle; go to IDLE.
//  Collection runs in ISSUE and DRAIN: when a token exits the pipe, capture sbox_out0/1.
//   - Write into nibble collect_cnt of state_out0/1 via right-shift insertion at bits[63:60].
//   - After 16 captures nibble i sits at bits[4i+3:4i].
//   - Then increment collect_cnt.
//  Collection order equals issue order; gaps from randomness stalls must not misalign results.
//  SBOX_LAT=0: capture happens in the issue cycle and DRAIN lasts 0 cycles.
//  Widths: issue_cnt and collect_cnt are 5 bits, range 0..16, no wrap.
//  A randomness word is consumed only on an issue and is never reused.
//  Reset mid-pass: immediate abort, all regs cleared, no done pulse.
//  state_out0/1 are not updated outside collection and hold through IDLE.
// TESTING
//  1 shares 64'h0/64'h0, rnd_valid=1 always, SBOX_LAT=1
//    -> done at cycle 18 after start; out0^out1 = 64'hCCCCCCCCCCCCCCCC.
//  2 share0 = 64'hFEDCBA9876543210^M, share1 = M (random M)
//    -> out0^out1 = 64'h21748FE3DA09B65C, for any M and any rnd_in.
//  3 rnd_valid toggles 1,0,0,1,... -> exactly 16 rnd handshakes, exactly 16 sbox_en pulses.
//    -> result identical to test 2; done 1 cycle after the last capture.
//  4 start pulsed again while busy -> ignored; a single done pulse; result unchanged.
//  5 rst asserted after the 7th issue -> busy/done/rnd_ready/sbox_en go 0 asynchronously.
//    -> a new start then yields the correct full result.
//  6 SBOX_LAT=0 and SBOX_LAT=3 runs of test 2 -> same result; done latency = 16+SBOX_LAT+1.

Source files
------------

// File: rtl/present_sbox_nibble_sequencer.sv
// Nibble-serial sequencer for a shared 2-share masked PRESENT S-box gadget.
// Issues one nibble per randomness word and collects results back into a 64-bit state.
module present_sbox_nibble_sequencer #(
  parameter int unsigned SBOX_LAT = 1,
  parameter int unsigned NIBBLES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] state_in0,
  input  logic [63:0] state_in1,
  output logic        busy,
  output logic        done,
  output logic [63:0] state_out0,
  output logic [63:0] state_out1,
  input  logic        rnd_valid,
  output logic        rnd_ready,
  input  logic [63:0] rnd_in,
  output logic        sbox_en,
  output logic [3:0]  sbox_in0,
  output logic [3:0]  sbox_in1,
  output logic [63:0] sbox_r,
  input  logic [3:0]  sbox_out0,
  input  logic [3:0]  sbox_out1
);

  localparam logic [4:0] LAST = 5'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  logic [63:0] sh0;
  logic [63:0] sh1;
  logic [4:0]  issue_cnt;
  logic [4:0]  collect_cnt;
  logic        issue;
  logic        tok_out;
  logic        capture;
  logic        last_cap;

  // rnd_ready is a registered copy of "in ISSUE", so an issue is exactly a handshake.
  assign issue    = rnd_ready && rnd_valid;
  assign capture  = tok_out && busy;
  assign last_cap = capture && (collect_cnt == LAST);

  always_comb begin
    sbox_en  = issue;
    sbox_in0 = '0;
    sbox_in1 = '0;
    sbox_r   = '0;
    if (issue) begin
      sbox_in0 = sh0[3:0];
      sbox_in1 = sh1[3:0];
      sbox_r   = rnd_in;
    end
  end

  // Token pipe mirrors the gadget latency so captures line up with issues despite bubbles.
  generate
    if (SBOX_LAT == 0) begin : g_comb
      assign tok_out = issue;
    end else begin : g_pipe
      logic [SBOX_LAT-1:0] tok_pipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tok_pipe <= '0;
        end else begin
          tok_pipe[0] <= issue;
          for (int unsigned i = 1; i < SBOX_LAT; i++) begin
            tok_pipe[i] <= tok_pipe[i-1];
          end
        end
      end

      assign tok_out = tok_pipe[SBOX_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rnd_ready   <= 1'b0;
      sh0         <= '0;
      sh1         <= '0;
      issue_cnt   <= '0;
      collect_cnt <= '0;
      state_out0  <= '0;
      state_out1  <= '0;
    end else begin
      done <= 1'b0;

      if (capture) begin
        state_out0  <= {sbox_out0, state_out0[63:4]};
        state_out1  <= {sbox_out1, state_out1[63:4]};
        collect_cnt <= collect_cnt + 5'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            sh0         <= state_in0;
            sh1         <= state_in1;
            issue_cnt   <= '0;
            collect_cnt <= '0;
            busy        <= 1'b1;
            rnd_ready   <= 1'b1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          if (issue) begin
            sh0       <= {4'h0, sh0[63:4]};
            sh1       <= {4'h0, sh1[63:4]};
            issue_cnt <= issue_cnt + 5'd1;
            if (issue_cnt == LAST) begin
              rnd_ready <= 1'b0;
              // With a combinational gadget the final capture lands in this same cycle.
              if (last_cap) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end

        DRAIN: begin
          if (last_cap) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_sbox_nibble_sequencer.sv
// Bench for present_sbox_nibble_sequencer: three lanes (gadget latency 0, 1, 3) share stimulus,
// each with its own masked gadget model; expected S-box layers are queued at start, checked at done.
module tb_present_sbox_nibble_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        rnd_valid;
  logic [63:0] state_in0;
  logic [63:0] state_in1;
  logic [63:0] rnd_in;

  logic        busy_w [3];
  logic        done_w [3];
  logic        rr_w   [3];
  logic        en_w   [3];
  logic [63:0] so0_w  [3];
  logic [63:0] so1_w  [3];
  logic [63:0] r_w    [3];
  logic [3:0]  in0_w  [3];
  logic [3:0]  in1_w  [3];
  logic [3:0]  out0_w [3];
  logic [3:0]  out1_w [3];

  typedef struct {
    logic [63:0] res;
    int          start_cyc;
    bit          no_bubble;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned nd [3];
  int          n_exp = 0;
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h21748FE3DA09B65C;
    return t[4*x +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sb(x[4*i +: 4]);
    return y;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [3:0] c0;
    logic [3:0] c1;
    logic       gv;

    present_sbox_nibble_sequencer #(.SBOX_LAT(LAT), .NIBBLES(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .state_in0 (state_in0),
      .state_in1 (state_in1),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .state_out0(so0_w[g]),
      .state_out1(so1_w[g]),
      .rnd_valid (rnd_valid),
      .rnd_ready (rr_w[g]),
      .rnd_in    (rnd_in),
      .sbox_en   (en_w[g]),
      .sbox_in0  (in0_w[g]),
      .sbox_in1  (in1_w[g]),
      .sbox_r    (r_w[g]),
      .sbox_out0 (out0_w[g]),
      .sbox_out1 (out1_w[g])
    );

    // Masked gadget model: shares of S(x) remasked with the supplied randomness.
    assign c0 = sb(in0_w[g] ^ in1_w[g]) ^ r_w[g][3:0];
    assign c1 = r_w[g][3:0];

    if (LAT == 0) begin : g_comb
      assign out0_w[g] = c0;
      assign out1_w[g] = c1;
      assign gv        = en_w[g];
    end else begin : g_pipe
      logic [3:0]     p0 [LAT];
      logic [3:0]     p1 [LAT];
      logic [LAT-1:0] pv;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv <= '0;
        end else begin
          pv[0] <= en_w[g];
          for (int i = 1; i < LAT; i++) pv[i] <= pv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        p0[0] <= c0;
        p1[0] <= c1;
        for (int i = 1; i < LAT; i++) begin
          p0[i] <= p0[i-1];
          p1[i] <= p1[i-1];
        end
      end

      assign out0_w[g] = p0[LAT-1];
      assign out1_w[g] = p1[LAT-1];
      assign gv        = pv[LAT-1];
    end

    initial begin
      int unsigned hs;
      int unsigned en;
      int          last_cap;
      hs       = 0;
      en       = 0;
      last_cap = -100;
      nd[g]    = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          hs = 0;
          en = 0;
        end else begin
          if (rnd_valid && rr_w[g]) hs++;
          if (en_w[g]) begin
            en++;
            check($sformatf("sbox_r_lane%0d", g), r_w[g], rnd_in);
          end else begin
            check($sformatf("idle_zero_lane%0d", g),
                  r_w[g] | 64'(in0_w[g]) | (64'(in1_w[g]) << 4), 64'h0);
          end
          if (gv) last_cap = cyc;
          if (done_w[g]) begin
            nd[g]++;
            check($sformatf("done_count_lane%0d", g), 64'(nd[g]), 64'(n_exp));
            check($sformatf("busy_at_done_lane%0d", g), 64'(busy_w[g]), 64'h0);
            if (exp_q.size() == 0) begin
              check($sformatf("done_unexpected_lane%0d", g), 64'h1, 64'h0);
            end else begin
              check($sformatf("result_lane%0d", g), so0_w[g] ^ so1_w[g], exp_q[0].res);
              check($sformatf("rnd_handshakes_lane%0d", g), 64'(hs), 64'd16);
              check($sformatf("sbox_en_pulses_lane%0d", g), 64'(en), 64'd16);
              check($sformatf("done_after_capture_lane%0d", g), 64'(cyc), 64'(last_cap + 1));
              if (exp_q[0].no_bubble)
                check($sformatf("done_latency_lane%0d", g),
                      64'(cyc - exp_q[0].start_cyc), 64'(16 + LAT + 1));
              if (g == 2) exp_q.delete(0);
            end
            hs = 0;
            en = 0;
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [63:0] res, input bit nb);
    exp_t e;
    e.res       = res;
    e.start_cyc = cyc;
    e.no_bubble = nb;
    exp_q.push_back(e);
    n_exp++;
  endtask

  // mode 0: randomness always valid; 1: valid pattern 1,0,0; 2: extra start while busy
  task automatic run_pass(input logic [63:0] s0, input logic [63:0] s1,
                          input logic [63:0] exp_res, input int mode);
    bit fin;
    fin = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    state_in0 = s0;
    state_in1 = s1;
    rnd_in    = {$urandom(), $urandom()};
    push_exp(exp_res, mode != 1);
    for (int k = 1; k <= 200 && !fin; k++) begin
      @(posedge clk); #1;
      start     = (mode == 2) && (k == 4);
      state_in0 = ~s0;
      rnd_valid = (mode == 1) ? (k % 3 == 1) : 1'b1;
      rnd_in    = {$urandom(), $urandom()};
      if (nd[2] == n_exp) fin = 1'b1;
    end
    start     = 1'b0;
    rnd_valid = 1'b1;
    check("pass_completed", 64'(nd[2]), 64'(n_exp));
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++)
      check($sformatf("hold_in_idle_lane%0d", g), so0_w[g] ^ so1_w[g], exp_res);
  endtask

  task automatic abort_pass();
    logic [63:0] m;
    m = {$urandom(), $urandom()};
    @(posedge clk); #1;
    start     = 1'b1;
    state_in0 = m;
    state_in1 = ~m;
    push_exp(64'h0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      rnd_valid = 1'b1;
      rnd_in    = {$urandom(), $urandom()};
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("abort_busy_lane%0d", g), 64'(busy_w[g]), 64'h0);
      check($sformatf("abort_done_lane%0d", g), 64'(done_w[g]), 64'h0);
      check($sformatf("abort_rnd_ready_lane%0d", g), 64'(rr_w[g]), 64'h0);
      check($sformatf("abort_sbox_en_lane%0d", g), 64'(en_w[g]), 64'h0);
      check($sformatf("abort_state_out_lane%0d", g), so0_w[g] | so1_w[g], 64'h0);
    end
    exp_q.delete(exp_q.size() - 1);
    n_exp--;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] m;
    logic [63:0] a;
    logic [63:0] b;
    rst       = 1'b1;
    start     = 1'b0;
    rnd_valid = 1'b0;
    state_in0 = '0;
    state_in1 = '0;
    rnd_in    = '0;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_busy_lane%0d", g), 64'(busy_w[g]), 64'h0);
      check($sformatf("reset_done_lane%0d", g), 64'(done_w[g]), 64'h0);
      check($sformatf("reset_rnd_ready_lane%0d", g), 64'(rr_w[g]), 64'h0);
      check($sformatf("reset_sbox_en_lane%0d", g), 64'(en_w[g]), 64'h0);
      check($sformatf("reset_state_out0_lane%0d", g), so0_w[g], 64'h0);
      check($sformatf("reset_state_out1_lane%0d", g), so1_w[g], 64'h0);
    end
    rst       = 1'b0;
    rnd_valid = 1'b1;

    run_pass(64'h0, 64'h0, 64'hCCCCCCCCCCCCCCCC, 0);
    for (int t = 0; t < 2; t++) begin
      m = {$urandom(), $urandom()};
      run_pass(64'hFEDCBA9876543210 ^ m, m, 64'h21748FE3DA09B65C, 0);
    end
    m = {$urandom(), $urandom()};
    run_pass(64'hFEDCBA9876543210 ^ m, m, 64'h21748FE3DA09B65C, 1);
    m = {$urandom(), $urandom()};
    run_pass(64'hFEDCBA9876543210 ^ m, m, 64'h21748FE3DA09B65C, 2);
    for (int t = 0; t < 3; t++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      run_pass(a, b, sbox_layer(a ^ b), t);
    end
    abort_pass();
    m = {$urandom(), $urandom()};
    run_pass(64'hFEDCBA9876543210 ^ m, m, 64'h21748FE3DA09B65C, 0);

    repeat (5) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++)
      check($sformatf("final_done_count_lane%0d", g), 64'(nd[g]), 64'(n_exp));
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
